// File: rtl/fetch_unit_pkg.sv
// Shared front-end constants and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned Xlen       = 32;
    localparam int unsigned InstrWidth = 32;
    localparam int unsigned PcInc      = 4;

    localparam logic [InstrWidth-1:0] NopInstr = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble is inserted.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           PcWidth     = Xlen,
    parameter logic [InstrWidth-1:0] BubbleInstr = NopInstr
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  load_i,
    input  logic [PcWidth-1:0]    pc_i,
    input  logic [InstrWidth-1:0] instr_i,
    output logic [PcWidth-1:0]    pc_o,
    output logic [InstrWidth-1:0] instr_o,
    output logic                  valid_o
);

    logic [PcWidth-1:0]    pc_q;
    logic [InstrWidth-1:0] instr_q;
    logic                  valid_q;

    // The PC field is left untouched by flush and bubble; only valid/instr are squashed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= BubbleInstr;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= BubbleInstr;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                pc_q    <= pc_i;
                instr_q <= instr_i;
                valid_q <= 1'b1;
            end else begin
                instr_q <= BubbleInstr;
                valid_q <= 1'b0;
            end
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests and IF/ID drive.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           XLEN      = Xlen,
    parameter logic [XLEN-1:0]       RESET_PC  = '0,
    parameter logic [InstrWidth-1:0] NOP_INSTR = NopInstr
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_stall,
    input  logic                  if_stall,
    input  logic                  if_flush,
    input  logic                  branch_taken,
    input  logic [XLEN-1:0]       branch_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [InstrWidth-1:0] imem_rdata,
    output logic [XLEN-1:0]       if_id_pc,
    output logic [InstrWidth-1:0] if_id_instr,
    output logic                  if_id_valid,
    output logic                  fetch_pending
);

    fetch_state_e          state_q;
    logic [XLEN-1:0]       pc_q;
    logic [InstrWidth-1:0] hold_instr_q;

    logic                  req_hs;
    logic                  redirect;
    logic                  deliver;
    logic [InstrWidth-1:0] deliver_instr;
    logic [XLEN-1:0]       pc_next_seq;

    // Gated by rst so nothing is presented to memory before the first reset edge.
    assign imem_req_valid = !rst && (state_q == StReq) && !pc_stall;
    assign imem_addr      = pc_q;
    assign fetch_pending  = !rst && (state_q inside {StWait, StDrop, StHold});

    assign req_hs      = imem_req_valid && imem_req_ready;
    assign redirect    = branch_taken || if_flush;
    assign pc_next_seq = pc_q + XLEN'(PcInc);

    always_comb begin
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        case (state_q)
            StWait: deliver = imem_rsp_valid && !redirect && !if_stall;
            StHold: begin
                deliver       = !redirect && !if_stall;
                deliver_instr = hold_instr_q;
            end
            default: deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (branch_taken) pc_q <= branch_target;
                    // A request accepted alongside a redirect fetches a stale address.
                    if (req_hs) state_q <= branch_taken ? StDrop : StWait;
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        if (redirect) begin
                            if (branch_taken) pc_q <= branch_target;
                            state_q <= StReq;
                        end else if (if_stall) begin
                            hold_instr_q <= imem_rdata;
                            state_q      <= StHold;
                        end else begin
                            pc_q    <= pc_next_seq;
                            state_q <= StReq;
                        end
                    end else if (redirect) begin
                        if (branch_taken) pc_q <= branch_target;
                        state_q <= StDrop;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        if (branch_taken) pc_q <= branch_target;
                        state_q <= StReq;
                    end else if (!if_stall) begin
                        pc_q    <= pc_next_seq;
                        state_q <= StReq;
                    end
                end
                StDrop: begin
                    if (branch_taken) pc_q <= branch_target;
                    if (imem_rsp_valid) state_q <= StReq;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fetch_unit_if_id_reg #(
        .PcWidth     (XLEN),
        .BubbleInstr (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (if_flush),
        .stall_i (if_stall),
        .load_i  (deliver),
        .pc_i    (pc_q),
        .instr_i (deliver_instr),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, then randomized traffic against a reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_stall, if_stall, if_flush, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid, fetch_pending;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_stall       (pc_stall),
        .if_stall       (if_stall),
        .if_flush       (if_flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_pending  (fetch_pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, ps, is, fl, bt;
        logic [31:0] tgt;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        ck, e_req;
        logic [31:0] e_addr;
        logic        e_pend, e_v;
        logic [31:0] e_ipc, e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, ps, is, fl, bt, input logic [31:0] tgt,
                       input logic rdy, rv, input logic [31:0] rdata,
                       input logic ck, ereq, input logic [31:0] eaddr,
                       input logic epend, ev, input logic [31:0] eipc, einstr);
        vec_t v;
        v.rst = r; v.ps = ps; v.is = is; v.fl = fl; v.bt = bt; v.tgt = tgt;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.ck = ck; v.e_req = ereq; v.e_addr = eaddr; v.e_pend = epend;
        v.e_v = ev; v.e_ipc = eipc; v.e_instr = einstr;
        vecs.push_back(v);
    endtask

    // Reference model state: abstract flags, not the DUT's state encoding.
    bit          m_started, m_busy, m_keep, m_held;
    logic [31:0] m_held_instr, m_pc;
    logic        m_v;
    logic [31:0] m_ipc, m_instr;

    task automatic model_step(input logic r, ps, is, fl, bt, input logic [31:0] tgt,
                              input logic rdy, rv, input logic [31:0] rdata);
        bit          req, hs, redir, deliver;
        logic [31:0] dinstr;
        deliver = 0;
        dinstr  = NOP;
        if (r) begin
            m_started = 0; m_busy = 0; m_keep = 0; m_held = 0;
            m_pc = 32'h0; m_v = 0; m_ipc = 32'h0; m_instr = NOP;
            return;
        end
        req   = m_started && !m_busy && !m_held && !ps;
        hs    = req && rdy;
        redir = bt || fl;
        if (!m_started) begin
            m_started = 1;
        end else if (m_held) begin
            if (redir) begin
                m_held = 0;
                if (bt) m_pc = tgt;
            end else if (!is) begin
                deliver = 1; dinstr = m_held_instr; m_held = 0;
            end
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 0;
                if (!m_keep || redir) begin
                    if (bt) m_pc = tgt;
                end else if (is) begin
                    m_held = 1; m_held_instr = rdata;
                end else begin
                    deliver = 1; dinstr = rdata;
                end
            end else begin
                if (bt) m_pc = tgt;
                if (redir) m_keep = 0;
            end
        end else begin
            if (bt) m_pc = tgt;
            if (hs) begin
                m_busy = 1; m_keep = !bt;
            end
        end
        if (fl) begin
            m_v = 0; m_instr = NOP;
        end else if (!is) begin
            if (deliver) begin
                m_v = 1; m_ipc = m_pc; m_instr = dinstr;
            end else begin
                m_v = 0; m_instr = NOP;
            end
        end
        if (deliver) m_pc = m_pc + 32'd4;
    endtask

    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;

    initial begin
        rst = 1; pc_stall = 0; if_stall = 0; if_flush = 0; branch_taken = 0;
        branch_target = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rdata = 0;

        // rst ps is fl bt tgt rdy rv rdata | ck req addr pend v ipc instr
        add(1,0,0,0,0,32'h0,1,0,32'h0,        0,0,32'h0,0,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,0,32'h0,0,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h0,0,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h00500093, 1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h4,0,1,32'h0,32'h00500093);
        add(0,0,0,0,0,32'h0,1,1,32'h00A00113, 1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h8,0,1,32'h4,32'h00A00113);
        add(0,0,1,0,0,32'h0,1,1,32'h00B00193, 1,0,32'h0,1,0,32'h4,NOP);
        add(0,0,1,0,0,32'h0,1,0,32'h0,        1,0,32'h0,1,0,32'h4,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,0,32'h0,1,0,32'h4,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'hC,0,1,32'h8,32'h00B00193);
        add(0,0,0,0,1,32'h100,1,0,32'h0,      1,0,32'h0,1,0,32'h8,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'hDEADBEEF, 1,0,32'h0,1,0,32'h8,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h100,0,0,32'h8,NOP);
        add(0,0,0,0,1,32'h10,1,1,32'h11111111,1,0,32'h0,1,0,32'h8,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h10,0,0,32'h8,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h00C00213, 1,0,32'h0,1,0,32'h8,NOP);
        add(0,0,0,1,0,32'h0,0,0,32'h0,        1,1,32'h14,0,1,32'h10,32'h00C00213);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h14,0,0,32'h10,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h00D00293, 1,0,32'h0,1,0,32'h10,NOP);
        add(0,0,1,1,0,32'h0,0,0,32'h0,        1,1,32'h18,0,1,32'h14,32'h00D00293);
        add(0,0,0,0,1,32'hFFFFFFFC,0,0,32'h0, 1,1,32'h18,0,0,32'h14,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'hFFFFFFFC,0,0,32'h14,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h00E00313, 1,0,32'h0,1,0,32'h14,NOP);
        add(0,0,0,0,0,32'h0,0,0,32'h0,        1,1,32'h0,0,1,32'hFFFFFFFC,32'h00E00313);
        add(1,1,0,0,0,32'h0,0,0,32'h0,        1,0,32'h0,0,0,32'hFFFFFFFC,NOP);
        add(0,1,0,0,0,32'h0,1,0,32'h0,        1,0,32'h0,0,0,32'h0,NOP);
        add(0,1,0,0,0,32'h0,1,0,32'h0,        1,0,32'h0,0,0,32'h0,NOP);
        add(0,1,0,0,0,32'h0,1,0,32'h0,        1,0,32'h0,0,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h0,0,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h00F00393, 1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,0,32'h0,        1,1,32'h4,0,1,32'h0,32'h00F00393);
        add(0,0,0,1,0,32'h0,1,0,32'h0,        1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,1,32'h40,1,0,32'h0,       1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,1,1,32'h12345678, 1,0,32'h0,1,0,32'h0,NOP);
        add(0,0,0,0,0,32'h0,0,0,32'h0,        1,1,32'h40,0,0,32'h0,NOP);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; pc_stall = vecs[i].ps; if_stall = vecs[i].is;
            if_flush = vecs[i].fl; branch_taken = vecs[i].bt; branch_target = vecs[i].tgt;
            imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rv;
            imem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
            check($sformatf("row%0d pending", i), 32'(fetch_pending), 32'(vecs[i].e_pend));
            if (vecs[i].e_req)
                check($sformatf("row%0d addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].ck) begin
                check($sformatf("row%0d if_id_valid", i), 32'(if_id_valid), 32'(vecs[i].e_v));
                check($sformatf("row%0d if_id_pc", i), if_id_pc, vecs[i].e_ipc);
                check($sformatf("row%0d if_id_instr", i), if_id_instr, vecs[i].e_instr);
            end
        end

        // Model starts from the IF/ID contents the table leaves behind.
        m_v = 0; m_ipc = 32'h0; m_instr = NOP;
        mem_busy = 0; mem_cnt = 0; mem_data = 0;
        for (int c = 0; c < 4000; c++) begin
            logic e_req, e_pend;
            @(negedge clk);
            rst            = (c == 0) || ($urandom_range(0, 299) == 0);
            pc_stall       = ($urandom_range(0, 4) == 0);
            if_stall       = ($urandom_range(0, 3) == 0);
            if_flush       = ($urandom_range(0, 11) == 0);
            branch_taken   = ($urandom_range(0, 11) == 0);
            branch_target  = ($urandom_range(0, 7) == 0) ? $urandom()
                                                         : {22'h0, 8'($urandom()), 2'b00};
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_valid = 0;
            imem_rdata     = $urandom();
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1; imem_rdata = mem_data; mem_busy = 0;
                end
            end
            #1;
            e_req  = !rst && m_started && !m_busy && !m_held && !pc_stall;
            e_pend = !rst && (m_busy || m_held);
            check($sformatf("rnd%0d req_valid", c), 32'(imem_req_valid), 32'(e_req));
            check($sformatf("rnd%0d pending", c), 32'(fetch_pending), 32'(e_pend));
            if (e_req) check($sformatf("rnd%0d addr", c), imem_addr, m_pc);
            check($sformatf("rnd%0d if_id_valid", c), 32'(if_id_valid), 32'(m_v));
            check($sformatf("rnd%0d if_id_pc", c), if_id_pc, m_ipc);
            check($sformatf("rnd%0d if_id_instr", c), if_id_instr, m_instr);
            model_step(rst, pc_stall, if_stall, if_flush, branch_taken, branch_target,
                       imem_req_ready, imem_rsp_valid, imem_rdata);
            if (rst) begin
                mem_busy = 0;
            end else if (imem_req_valid && imem_req_ready && !mem_busy) begin
                mem_busy = 1; mem_cnt = $urandom_range(1, 3); mem_data = $urandom();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage: owns the PC, issues requests to instruction memory over a valid/ready interface, and drives the IF/ID pipeline register. It obeys the stall, flush and redirect controls from hazard_unit (pc_stall, if_stall, if_flush, branch_taken). One memory request is outstanding at most; a one-entry hold buffer absorbs a response that arrives while IF/ID is stalled.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset/flush/bubble

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
pc_stall  in  1  from hazard_unit: hold PC, do not issue new request
if_stall  in  1  from hazard_unit: hold IF/ID register contents
if_flush  in  1  from hazard_unit: squash IF/ID and in-flight fetch
branch_taken  in  1  redirect PC to branch_target
branch_target  in  XLEN  redirect address from EX
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  instruction data valid (exactly one per accepted request, >=1 cycle later)
imem_rdata  in  32  instruction word
if_id_pc  out  XLEN  PC of instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction
fetch_pending  out  1  request accepted, response not yet consumed

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, state<=S_IDLE, if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc<=0, hold buffer empty. imem_req_valid=0, fetch_pending=0 during reset. Reset mid-transaction: in-flight response is not tracked (memory is reset with the core).
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP.
- S_IDLE: unconditionally -> S_REQ next cycle.
- S_REQ: imem_req_valid = !pc_stall; imem_addr = pc. Handshake (valid&ready) -> S_WAIT. branch_taken with no handshake: pc<=branch_target, stay S_REQ. branch_taken with handshake in the same cycle: pc<=branch_target, -> S_DROP.
- S_WAIT: on rsp_valid and no redirect/flush: if if_stall=0, load IF/ID {pc, rdata, valid=1}, pc<=pc+4, -> S_REQ; if if_stall=1, capture into hold buffer, -> S_HOLD. branch_taken or if_flush without rsp: pc<=branch_target (branch_taken) or unchanged (flush only), -> S_DROP. Redirect/flush coincident with rsp: response discarded, -> S_REQ.
- S_HOLD: when if_stall=0, move buffer into IF/ID, pc<=pc+4, -> S_REQ. branch_taken/if_flush: discard buffer, apply redirect, -> S_REQ.
- S_DROP: wait for rsp_valid, discard data, -> S_REQ. Further branch_taken in S_DROP updates pc only.
- IF/ID register priority: if_flush > if_stall > load. Flush: valid<=0, instr<=NOP_INSTR. Stall: hold all fields. Otherwise, with no instruction delivered this cycle: bubble (valid<=0, instr<=NOP_INSTR).
- fetch_pending = state in {S_WAIT, S_DROP, S_HOLD}.
- PC arithmetic: pc+4 modulo 2^XLEN (wraps at top of address space); branch_target low 2 bits are used as given, with no alignment check.
- Best-case throughput: one instruction every 2 cycles with 1-cycle memory latency (no overlap by design).

Decomposition:
- Shared pipeline package: NOP_INSTR constant, XLEN, fetch state encoding (S_IDLE..S_DROP), PC increment constant 4.
- Sub-module if_id_reg: IF/ID register with flush/stall priority, reused by later stage registers. The FSM and PC stay in fetch_unit.

Test Plan:
- Reset release, ready=1, 1-cycle latency, rdata=0x00500093 -> first req addr 0x0, if_id_pc=0x0, if_id_instr=0x00500093, valid=1; next addr 0x4.
- Reset release with pc_stall=1 for 3 cycles -> imem_req_valid=0 throughout; first request issued cycle after pc_stall drops, addr=0x0.
- Response at pc=0x8 while if_stall=1 for 2 cycles -> fetch_pending=1, IF/ID unchanged; after release if_id_pc=0x8, next addr 0xC.
- branch_taken, target 0x100, in S_WAIT before response -> response discarded (if_id_valid stays 0), next req addr 0x100.
- branch_taken coincident with rsp_valid -> data discarded, next req addr = target, no S_DROP wait.
- if_flush while IF/ID valid at pc=0x10 -> next cycle if_id_valid=0, if_id_instr=0x00000013; if_flush+if_stall together -> flush wins.
